async_fifo_wr_arbiter: RTL and testbench
========================================

# async_fifo_wr_arbiter

Round-robin write-port arbiter that shares the async FIFO's single write interface (winc/wdata/wfull) among NUM_REQ requesters in the write clock domain. Each requester presents a valid/ready stream. The arbiter grants one requester at a time for a bounded burst of up to MAX_BURST beats. It forwards that requester's data to the FIFO, back-pressures on wfull, and keeps a saturating count of accepted writes.

## Interface
- NUM_REQ, 4: number of requesters; must be ≥ 2.
- DATA_WIDTH, 8: FIFO data width.
- MAX_BURST, 4: maximum beats per grant; must be ≥ 1.

- wclk  input  1  write-domain clock; the only clock in this block.
- wrst_n  input  1  reset; synchronous, active-low.
- req_valid  input  NUM_REQ  per-requester data valid.
- req_data  input  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  per-requester beat accepted; one-hot or zero.
- wfull  input  1  FIFO full flag, already in the wclk domain.
- winc  output  1  FIFO write enable.
- wdata  output  DATA_WIDTH  FIFO write data.
- busy  output  1  high while a grant is held.
- grant_id  output  $clog2(NUM_REQ)  index of the current or most recent grantee.
- xfer_count  output  16  total accepted writes; saturates at 16'hFFFF.

## Operation
- Registered state:
  - state ∈ {IDLE, GRANT}
  - rr_ptr, width $clog2(NUM_REQ)
  - beat_cnt, width max(1, $clog2(MAX_BURST))
  - grant_id
  - xfer_count
- IDLE:
  - If any req_valid is high, select the first asserted index searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Register that index into grant_id, clear beat_cnt, and go to GRANT.
  - No transfer occurs in IDLE.
- GRANT, with g = grant_id:
  - req_ready[g] = !wfull. All other req_ready bits are 0.
  - winc = req_valid[g] & !wfull.
  - wdata = req_data[g], driven combinationally and always muxed from grant_id, including in IDLE.
- On a transfer (winc = 1):
  - xfer_count increments unless already at 16'hFFFF.
  - beat_cnt increments.
- Release conditions: GRANT goes to IDLE on the same edge if either holds:
  - a transfer occurs with beat_cnt == MAX_BURST-1;
  - req_valid[g] == 0, in which case there is no transfer that cycle.
- On release, rr_ptr ← (g+1) mod NUM_REQ. Modulo wrap applies for non-power-of-two NUM_REQ.
- When wfull is high in GRANT:
  - winc = 0 and req_ready[g] = 0.
  - beat_cnt holds and the grant is held indefinitely.
- Requester obligation: req_data stays stable and req_valid stays high while req_valid && !req_ready. Dropping valid forfeits the grant.
- busy = (state == GRANT).

## Timing
- Reset, on a wclk edge with wrst_n = 0:
  - state = IDLE, rr_ptr = 0, beat_cnt = 0, grant_id = 0, xfer_count = 0.
- While wrst_n = 0, winc and req_ready are forced to 0 combinationally.
  - busy follows the registered state, so it reads 0 from the first reset edge onward.
- Reset mid-burst: the beat offered in the reset cycle is not written. The arbiter is in IDLE after that edge.
- Grant latency: req_valid rising in IDLE gives the first possible winc one cycle later.
- Throughput:
  - 1 beat/cycle within a burst.
  - Exactly one idle bubble cycle after every release, before the next grant.
- Burst boundary: the MAX_BURST-th beat and the release happen on the same edge. The next cycle is IDLE.
- A requester releasing with no other requesters active is re-granted after the bubble, because the search wraps back to it.
- Simultaneous wfull deassertion and valid drop: no transfer, release. The valid check has priority.
- MAX_BURST = 1: every beat releases the grant, giving an alternating GRANT/IDLE pattern at 50% throughput.

## Test plan
- Single requester, MAX_BURST = 4: req 0 streams 6 beats D0..D5 with wfull = 0.
  - Required: winc high for 4 cycles (D0..D3), 1 idle cycle with busy = 0, then 2 cycles (D4, D5).
  - xfer_count = 6, grant_id = 0.
- All 4 requesters continuously valid from reset release.
  - Required grant order 0, 1, 2, 3, 0, with 4 beats each, a bubble between grants, and wdata taken from the granted lane only.
- wfull high for 3 cycles after beat 2 of a burst from req 1.
  - Required: winc = 0 and req_ready = 0 for those 3 cycles, with beat_cnt and wdata held.
  - Burst then completes beats 3–4. xfer_count advances by 4 total.
- req 2 drops valid after 2 beats while req 3 is waiting.
  - Required: release on the drop cycle, 1 bubble, then grant_id = 3 and req 3's data written.
- wrst_n low mid-burst (beat 2 of 4) for 1 cycle.
  - Required: no winc in the reset cycle; state IDLE and rr_ptr = 0 after it; xfer_count = 0.
  - Re-arbitration starts from index 0.

Source files
------------

// File: rtl/async_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// async_fifo_wr_arbiter
//
// Round-robin arbiter sharing the write side of an async FIFO among NUM_REQ
// valid/ready requesters, all in the wclk domain. A grant lasts for up to
// MAX_BURST accepted beats, or until the grantee drops valid, and is followed
// by exactly one IDLE bubble cycle before the next grant.
//
// Ports:
//   wclk        write-domain clock
//   wrst_n      synchronous active-low reset
//   req_valid   per-requester valid
//   req_data    packed requester data, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready   per-requester beat accepted (one-hot or zero)
//   wfull       FIFO full flag (already in wclk domain)
//   winc        FIFO write enable
//   wdata       FIFO write data, always muxed from grant_id
//   busy        high while a grant is held
//   grant_id    current or most recent grantee
//   xfer_count  saturating count of accepted writes
// -----------------------------------------------------------------------------
module async_fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          wclk,
    input  logic                          wrst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          wfull,
    output logic                          winc,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic [15:0]                   xfer_count
);

    localparam int GID_W  = $clog2(NUM_REQ);
    localparam int BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);
    localparam logic [GID_W-1:0]  LAST_REQ  = GID_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                  state_r, state_nx;
    logic [GID_W-1:0]        rr_ptr_r, rr_ptr_nx;
    logic [GID_W-1:0]        grant_id_r, grant_id_nx;
    logic [BEAT_W-1:0]       beat_cnt_r, beat_cnt_nx;
    logic [15:0]             xfer_count_r, xfer_count_nx;

    logic [DATA_WIDTH-1:0]   lane_s [NUM_REQ];
    logic [GID_W:0]          pick_s;
    logic                    gnt_valid_s;
    logic                    xfer_s;
    logic [GID_W-1:0]        rr_next_s;

    // Round-robin search: first asserted valid at or above ptr, wrapping
    // modulo NUM_REQ (also for non-power-of-two NUM_REQ). Returns {found, idx}.
    function automatic logic [GID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                               input logic [GID_W-1:0]   ptr);
        logic [GID_W:0]   sum;
        logic [GID_W-1:0] cand;
        logic [GID_W-1:0] idx;
        logic             found;
        logic             hit;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum   = {1'b0, ptr} + (GID_W+1)'(i);
            // ptr and i are both below NUM_REQ, so one subtraction wraps it
            cand  = (sum >= (GID_W+1)'(NUM_REQ)) ? GID_W'(sum - (GID_W+1)'(NUM_REQ))
                                                 : sum[GID_W-1:0];
            hit   = !found && valid[cand];
            idx   = hit ? cand : idx;
            found = found | hit;
        end
        return {found, idx};
    endfunction

    // Unpack requester lanes for the write-data mux
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        assign lane_s[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    assign pick_s      = rr_pick(req_valid, rr_ptr_r);
    assign gnt_valid_s = req_valid[grant_id_r];
    assign rr_next_s   = (grant_id_r == LAST_REQ) ? {GID_W{1'b0}} : grant_id_r + GID_W'(1);
    // Reset forces the write strobe low so the beat offered in a reset cycle is dropped
    assign xfer_s      = wrst_n && (state_r == GRANT) && gnt_valid_s && !wfull;

    // Next-state logic: arbitration in IDLE, burst tracking and release in GRANT
    always_comb begin
        state_nx    = state_r;
        rr_ptr_nx   = rr_ptr_r;
        grant_id_nx = grant_id_r;
        beat_cnt_nx = beat_cnt_r;
        case (state_r)
            IDLE: begin
                if (pick_s[GID_W]) begin
                    grant_id_nx = pick_s[GID_W-1:0];
                    beat_cnt_nx = {BEAT_W{1'b0}};
                    state_nx    = GRANT;
                end else begin
                    state_nx    = IDLE;
                end
            end
            GRANT: begin
                // A dropped valid releases even if wfull is also changing
                if (!gnt_valid_s) begin
                    state_nx  = IDLE;
                    rr_ptr_nx = rr_next_s;
                end else if (xfer_s) begin
                    beat_cnt_nx = beat_cnt_r + BEAT_W'(1);
                    if (beat_cnt_r == LAST_BEAT) begin
                        state_nx  = IDLE;
                        rr_ptr_nx = rr_next_s;
                    end else begin
                        state_nx  = GRANT;
                    end
                end else begin
                    // wfull stall: hold grant and beat count
                    state_nx = GRANT;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Saturating accepted-write counter
    always_comb begin
        if (xfer_s && (xfer_count_r != 16'hFFFF)) begin
            xfer_count_nx = xfer_count_r + 16'd1;
        end else begin
            xfer_count_nx = xfer_count_r;
        end
    end

    // State and counter registers with synchronous active-low reset
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            state_r      <= IDLE;
            rr_ptr_r     <= {GID_W{1'b0}};
            grant_id_r   <= {GID_W{1'b0}};
            beat_cnt_r   <= {BEAT_W{1'b0}};
            xfer_count_r <= 16'd0;
        end else begin
            state_r      <= state_nx;
            rr_ptr_r     <= rr_ptr_nx;
            grant_id_r   <= grant_id_nx;
            beat_cnt_r   <= beat_cnt_nx;
            xfer_count_r <= xfer_count_nx;
        end
    end

    // Ready goes only to the grantee, gated by wfull and reset
    always_comb begin
        req_ready = {NUM_REQ{1'b0}};
        if (wrst_n && (state_r == GRANT)) begin
            req_ready[grant_id_r] = !wfull;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
    end

    assign winc       = xfer_s;
    assign wdata      = lane_s[grant_id_r];
    assign busy       = (state_r == GRANT);
    assign grant_id   = grant_id_r;
    assign xfer_count = xfer_count_r;

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_async_fifo_wr_arbiter
//
// Directed bench for async_fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8,
// MAX_BURST=4). Each cycle applies one vector shortly after the rising edge
// and compares all outputs on the falling edge against hand-computed values.
// -----------------------------------------------------------------------------
module tb_async_fifo_wr_arbiter;

    logic        wclk;
    logic        wrst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        wfull;
    logic        winc;
    logic [7:0]  wdata;
    logic        busy;
    logic [1:0]  grant_id;
    logic [15:0] xfer_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst_n;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        full;
        logic        e_winc;
        logic [7:0]  e_wdata;
        logic [3:0]  e_ready;
        logic        e_busy;
        logic [1:0]  e_gid;
        logic [15:0] e_cnt;
    } vec_t;

    async_fifo_wr_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .MAX_BURST  (4)
    ) dut (
        .wclk       (wclk),
        .wrst_n     (wrst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .wfull      (wfull),
        .winc       (winc),
        .wdata      (wdata),
        .busy       (busy),
        .grant_id   (grant_id),
        .xfer_count (xfer_count)
    );

    // 10 ns write clock
    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    function automatic vec_t mk(input logic rst_n, input logic [3:0] valid,
                                input logic [31:0] data, input logic full,
                                input logic e_winc, input logic [7:0] e_wdata,
                                input logic [3:0] e_ready, input logic e_busy,
                                input logic [1:0] e_gid, input logic [15:0] e_cnt);
        vec_t v;
        v.rst_n = rst_n;   v.valid = valid;     v.data = data;       v.full = full;
        v.e_winc = e_winc; v.e_wdata = e_wdata; v.e_ready = e_ready;
        v.e_busy = e_busy; v.e_gid = e_gid;     v.e_cnt = e_cnt;
        return v;
    endfunction

    function automatic logic [7:0] lane_val(input int i, input int n);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(i);
        lo = 4'(n);
        return {hi, lo};
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    // Drive one vector (called just after a rising edge), check on the
    // falling edge, then advance to just after the next rising edge.
    task automatic step(input vec_t v, input string tag, input int idx);
        wrst_n    = v.rst_n;
        req_valid = v.valid;
        req_data  = v.data;
        wfull     = v.full;
        @(negedge wclk);
        chk({tag, ".winc"},       idx, 32'(winc),       32'(v.e_winc));
        chk({tag, ".wdata"},      idx, 32'(wdata),      32'(v.e_wdata));
        chk({tag, ".req_ready"},  idx, 32'(req_ready),  32'(v.e_ready));
        chk({tag, ".busy"},       idx, 32'(busy),       32'(v.e_busy));
        chk({tag, ".grant_id"},   idx, 32'(grant_id),   32'(v.e_gid));
        chk({tag, ".xfer_count"}, idx, 32'(xfer_count), 32'(v.e_cnt));
        @(posedge wclk);
        #1;
    endtask

    vec_t tbl[$];

    initial begin
        int          order [5];
        int          nb [4];
        int          cnt;
        int          gp;
        int          g;
        logic [31:0] d;

        wrst_n    = 1'b0;
        req_valid = 4'b0000;
        req_data  = 32'h0000_0000;
        wfull     = 1'b0;
        repeat (2) @(posedge wclk);
        #1;

        // Single requester 0 streaming D0..D5; lane 0 holds the beat number
        //              rst   valid    data           full  winc  wdata  ready    busy  gid   cnt
        tbl.push_back(mk(1'b0, 4'b0001, 32'h0000_0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0, 16'd0));
        tbl.push_back(mk(1'b1, 4'b0001, 32'h0000_0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0, 16'd0));
        tbl.push_back(mk(1'b1, 4'b0001, 32'h0000_0000, 1'b0, 1'b1, 8'h00, 4'b0001, 1'b1, 2'd0, 16'd0));
        tbl.push_back(mk(1'b1, 4'b0001, 32'h0000_0001, 1'b0, 1'b1, 8'h01, 4'b0001, 1'b1, 2'd0, 16'd1));
        tbl.push_back(mk(1'b1, 4'b0001, 32'h0000_0002, 1'b0, 1'b1, 8'h02, 4'b0001, 1'b1, 2'd0, 16'd2));
        tbl.push_back(mk(1'b1, 4'b0001, 32'h0000_0003, 1'b0, 1'b1, 8'h03, 4'b0001, 1'b1, 2'd0, 16'd3));
        // bubble after the 4th beat, then re-grant of the same requester
        tbl.push_back(mk(1'b1, 4'b0001, 32'h0000_0004, 1'b0, 1'b0, 8'h04, 4'b0000, 1'b0, 2'd0, 16'd4));
        tbl.push_back(mk(1'b1, 4'b0001, 32'h0000_0004, 1'b0, 1'b1, 8'h04, 4'b0001, 1'b1, 2'd0, 16'd4));
        tbl.push_back(mk(1'b1, 4'b0001, 32'h0000_0005, 1'b0, 1'b1, 8'h05, 4'b0001, 1'b1, 2'd0, 16'd5));
        // valid drops: no transfer, ready still shown, release
        tbl.push_back(mk(1'b1, 4'b0000, 32'h0000_0005, 1'b0, 1'b0, 8'h05, 4'b0001, 1'b1, 2'd0, 16'd6));
        tbl.push_back(mk(1'b1, 4'b0000, 32'h0000_0005, 1'b0, 1'b0, 8'h05, 4'b0000, 1'b0, 2'd0, 16'd6));
        // reset with all requesters valid: nothing happens in the reset cycle
        tbl.push_back(mk(1'b0, 4'b1111, 32'h0000_0005, 1'b0, 1'b0, 8'h05, 4'b0000, 1'b0, 2'd0, 16'd6));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], "tbl", i);
        end

        // All four requesters valid from reset release: grants 0,1,2,3,0
        order = '{0, 1, 2, 3, 0};
        nb    = '{0, 0, 0, 0};
        cnt   = 0;
        gp    = 0;
        for (int k = 0; k < 5; k++) begin
            g = order[k];
            for (int i = 0; i < 4; i++) d[i*8 +: 8] = lane_val(i, nb[i]);
            step(mk(1'b1, 4'b1111, d, 1'b0, 1'b0, lane_val(gp, nb[gp]), 4'b0000,
                    1'b0, 2'(gp), 16'(cnt)), "rr_bubble", k);
            for (int b = 0; b < 4; b++) begin
                for (int i = 0; i < 4; i++) d[i*8 +: 8] = lane_val(i, nb[i]);
                step(mk(1'b1, 4'b1111, d, 1'b0, 1'b1, lane_val(g, nb[g]), 4'(1 << g),
                        1'b1, 2'(g), 16'(cnt)), "rr_beat", k * 4 + b);
                nb[g]++;
                cnt++;
            end
            gp = g;
        end

        // wfull stall for 3 cycles after beat 2 of a burst from req 1
        step(mk(1'b1, 4'b0010, 32'h0000_A000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0, 16'd20), "full", 0);
        step(mk(1'b1, 4'b0010, 32'h0000_A000, 1'b0, 1'b1, 8'hA0, 4'b0010, 1'b1, 2'd1, 16'd20), "full", 1);
        step(mk(1'b1, 4'b0010, 32'h0000_A100, 1'b0, 1'b1, 8'hA1, 4'b0010, 1'b1, 2'd1, 16'd21), "full", 2);
        for (int s = 0; s < 3; s++) begin
            step(mk(1'b1, 4'b0010, 32'h0000_A200, 1'b1, 1'b0, 8'hA2, 4'b0000, 1'b1, 2'd1, 16'd22), "full_stall", s);
        end
        step(mk(1'b1, 4'b0010, 32'h0000_A200, 1'b0, 1'b1, 8'hA2, 4'b0010, 1'b1, 2'd1, 16'd22), "full", 3);
        step(mk(1'b1, 4'b0010, 32'h0000_A300, 1'b0, 1'b1, 8'hA3, 4'b0010, 1'b1, 2'd1, 16'd23), "full", 4);
        step(mk(1'b1, 4'b0000, 32'h0000_A300, 1'b0, 1'b0, 8'hA3, 4'b0000, 1'b0, 2'd1, 16'd24), "full", 5);

        // Reset mid-burst (req 2, beat 2): rr_ptr was 2, afterwards search restarts at 0
        step(mk(1'b1, 4'b0100, 32'h00E0_0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd1, 16'd24), "mrst", 0);
        step(mk(1'b1, 4'b0100, 32'h00E0_0000, 1'b0, 1'b1, 8'hE0, 4'b0100, 1'b1, 2'd2, 16'd24), "mrst", 1);
        step(mk(1'b0, 4'b0110, 32'h00E1_B000, 1'b0, 1'b0, 8'hE1, 4'b0000, 1'b1, 2'd2, 16'd25), "mrst", 2);
        step(mk(1'b1, 4'b0110, 32'h00E1_B000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0, 16'd0),  "mrst", 3);
        step(mk(1'b1, 4'b0110, 32'h00E1_B000, 1'b0, 1'b1, 8'hB0, 4'b0010, 1'b1, 2'd1, 16'd0),  "mrst", 4);
        step(mk(1'b1, 4'b0000, 32'h00E1_B000, 1'b0, 1'b0, 8'hB0, 4'b0010, 1'b1, 2'd1, 16'd1),  "mrst", 5);
        step(mk(1'b1, 4'b0000, 32'h00E1_B000, 1'b0, 1'b0, 8'hB0, 4'b0000, 1'b0, 2'd1, 16'd1),  "mrst", 6);

        // req 2 drops valid after 2 beats while req 3 waits
        step(mk(1'b1, 4'b1100, 32'hD0C0_0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd1, 16'd1), "drop", 0);
        step(mk(1'b1, 4'b1100, 32'hD0C0_0000, 1'b0, 1'b1, 8'hC0, 4'b0100, 1'b1, 2'd2, 16'd1), "drop", 1);
        step(mk(1'b1, 4'b1100, 32'hD0C1_0000, 1'b0, 1'b1, 8'hC1, 4'b0100, 1'b1, 2'd2, 16'd2), "drop", 2);
        step(mk(1'b1, 4'b1000, 32'hD0C2_0000, 1'b0, 1'b0, 8'hC2, 4'b0100, 1'b1, 2'd2, 16'd3), "drop", 3);
        step(mk(1'b1, 4'b1000, 32'hD0C2_0000, 1'b0, 1'b0, 8'hC2, 4'b0000, 1'b0, 2'd2, 16'd3), "drop", 4);
        step(mk(1'b1, 4'b1000, 32'hD0C2_0000, 1'b0, 1'b1, 8'hD0, 4'b1000, 1'b1, 2'd3, 16'd3), "drop", 5);
        step(mk(1'b1, 4'b0000, 32'hD1C2_0000, 1'b0, 1'b0, 8'hD1, 4'b1000, 1'b1, 2'd3, 16'd4), "drop", 6);
        step(mk(1'b1, 4'b0000, 32'hD1C2_0000, 1'b0, 1'b0, 8'hD1, 4'b0000, 1'b0, 2'd3, 16'd4), "drop", 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
